ysyx_23060229_wbu: RTL and testbench
====================================

# ysyx_23060229_wbu

Writeback unit: the write-side driver for the 32-entry general-purpose register file. Accepts results from the execute unit (EXU) and load/store unit (LSU) through valid/ready handshakes, buffers each in a single-entry slot, and retires them in acceptance order, one per cycle, onto the register file's write port (`wen`/`addr_in`/`din`). It also provides a busy scoreboard for operand-read hazards.

## Interface
- `ADDR_WIDTH`, default 5, register index width.
- `DATA_WIDTH`, default 32, register data width.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `exu_valid`  input  1  EXU result offered.
- `exu_ready`  output  1  EXU slot can accept.
- `exu_wen`  input  1  result writes a register. 0 means commit only.
- `exu_rd`  input  ADDR_WIDTH  destination index.
- `exu_data`  input  DATA_WIDTH  result value.
- `lsu_valid`, `lsu_ready`, `lsu_wen`, `lsu_rd`, `lsu_data`: same as the EXU group, for load results.
- `rf_wen`  output  1  register file write enable (registered).
- `rf_addr`  output  ADDR_WIDTH  write index (registered).
- `rf_din`  output  DATA_WIDTH  write data (registered).
- `commit`  output  1  one-cycle pulse per retired result (registered).
- `query_addr1`, `query_addr2`  input  ADDR_WIDTH  operand indices being read.
- `busy1`, `busy2`  output  1  a pending write targets the queried index (combinational).
- `fwd_valid1`, `fwd_valid2`  output  1  forwarded value available. Present only with the macro enabled.
- `fwd_data1`, `fwd_data2`  output  DATA_WIDTH  forwarded value. Present only with the macro enabled.

## Operation
- There are two slots, EXU and LSU. Each slot holds `valid`, `wen`, `rd` and `data`.
- An `age` bit records which occupied slot is older.
- **Accept:** a slot loads on `X_valid & X_ready`.
- `X_ready = ~slot_valid | slot_drains_this_cycle`.
- **Drain:** each cycle, at most one occupied slot moves into the output register.
  - The older slot drains first.
  - If only one slot is occupied, that slot drains.
  - If both slots are accepted on the same edge while both were empty, LSU is older.
  - A slot accepted while the other slot is occupied is younger.
- **Output register:**
  - `rf_wen = drained.wen & (drained.rd != 0)`.
  - `rf_addr = drained.rd`.
  - `rf_din = drained.data`.
  - `commit` = 1 for every drain.
  - With no drain, `rf_wen` and `commit` are 0; `rf_addr` and `rf_din` hold their values.
- **x0:** results for rd=0 are accepted and retired (`commit` pulses), but `rf_wen` stays 0.
- **Busy:** `busyN = 1` when `query_addrN != 0` and it matches the `rd` of either of these with `wen=1`:
  - a valid slot;
  - the output register while `rf_wen=1`.
- **Reset** (asynchronous, any time, including mid-operation):
  - both slots are cleared; pending results are dropped.
  - `age` = 0.
  - `rf_wen` = 0, `rf_addr` = 0, `rf_din` = 0, `commit` = 0.
  - after reset, `exu_ready` = `lsu_ready` = 1.

## Timing
- A result accepted at edge N drains at edge N+1 at the earliest. `rf_wen`/`commit` are then high from N+1 to N+2, and the register file writes at edge N+2.
- A result blocked by an older slot drains one edge later per blocking entry.
- Throughput is one retire per cycle.
- A slot that drains at an edge may accept a new result at the same edge.
- Both handshakes may complete in the same cycle. Only one of the two slots drains in that cycle.
- When both slots are occupied and neither drains, the producer must hold `valid` and its payload stable while `ready` is 0.
- `busy1`/`busy2` and `fwd_*` are combinational from state and the query inputs. There is no added latency.

## Configuration
- `YSYX_23060229_WB_FORWARD_EN` defined:
  - `fwd_validN` is asserted under the same condition as `busyN`.
  - `fwd_dataN` returns the youngest match. Priority: the younger slot, then the older slot, then the output register.
- Not defined:
  - the `fwd_*` ports and their logic are absent.
  - `busy1`/`busy2` are unchanged.

## Test plan
- **Reset:** assert `rst`=0 mid-stream with both slots full → outputs immediately go to `rf_wen`=0, `rf_addr`=0, `rf_din`=0, `commit`=0. After release, both ready signals = 1 and no stale write appears.
- **Single write:** EXU offers rd=5, data=0xDEADBEEF, wen=1 at edge N → `rf_wen`=1, `rf_addr`=5, `rf_din`=0xDEADBEEF and `commit`=1 during N+1..N+2. `busy` for query 5 is 1 from N until N+2.
- **x0:** LSU offers rd=0, data=0x12345678 → `commit` pulses once, `rf_wen` stays 0. `busy` for query 0 is always 0.
- **Ordering:** both offer in the same cycle (LSU rd=3 / 0xA, EXU rd=3 / 0xB) → LSU retires first, then EXU in the next cycle; the final r3 is 0xB. With forwarding enabled, `fwd_data` for query 3 shows 0xB while both are pending.
- **Backpressure:**
  - Fill both slots, then keep `exu_valid` high → `exu_ready` stays 0 until the EXU slot drains.
  - No result is lost or duplicated across 100 random valid/rd/data cycles; the retired sequence matches the accept order.
- **Back-to-back:** EXU streams rd=1..8 on consecutive cycles → eight consecutive `commit` pulses with no bubbles, in order.

Source files
------------

// File: rtl/ysyx_23060229_wbu.sv
// Writeback unit: two single-entry result slots (EXU, LSU) retired oldest-first onto the
// register-file write port, plus a pending-write scoreboard. Optional operand forwarding is
// compiled in with the YSYX_23060229_WB_FORWARD_EN macro.
module ysyx_23060229_wbu #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  exu_valid_i,
    output logic                  exu_ready_o,
    input  logic                  exu_wen_i,
    input  logic [ADDR_WIDTH-1:0] exu_rd_i,
    input  logic [DATA_WIDTH-1:0] exu_data_i,

    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic                  lsu_wen_i,
    input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,

    output logic                  rf_wen_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0] rf_din_o,
    output logic                  commit_o,

    input  logic [ADDR_WIDTH-1:0] query_addr1_i,
    input  logic [ADDR_WIDTH-1:0] query_addr2_i,
`ifdef YSYX_23060229_WB_FORWARD_EN
    output logic                  fwd_valid1_o,
    output logic                  fwd_valid2_o,
    output logic [DATA_WIDTH-1:0] fwd_data1_o,
    output logic [DATA_WIDTH-1:0] fwd_data2_o,
`endif
    output logic                  busy1_o,
    output logic                  busy2_o
);

    // Slot state
    logic                  exu_vld_q, exu_vld_d;
    logic                  exu_wen_q, exu_wen_d;
    logic [ADDR_WIDTH-1:0] exu_rd_q, exu_rd_d;
    logic [DATA_WIDTH-1:0] exu_data_q, exu_data_d;

    logic                  lsu_vld_q, lsu_vld_d;
    logic                  lsu_wen_q, lsu_wen_d;
    logic [ADDR_WIDTH-1:0] lsu_rd_q, lsu_rd_d;
    logic [DATA_WIDTH-1:0] lsu_data_q, lsu_data_d;

    // 1: the LSU slot holds the older result; only meaningful with both slots occupied.
    logic                  age_q, age_d;

    // Output register
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_din_q, rf_din_d;
    logic                  commit_q, commit_d;

    logic drain_exu, drain_lsu;
    logic acc_exu, acc_lsu;

    always_comb begin
        drain_exu   = exu_vld_q & (~lsu_vld_q | ~age_q);
        drain_lsu   = lsu_vld_q & (~exu_vld_q | age_q);
        exu_ready_o = ~exu_vld_q | drain_exu;
        lsu_ready_o = ~lsu_vld_q | drain_lsu;
        acc_exu     = exu_valid_i & exu_ready_o;
        acc_lsu     = lsu_valid_i & lsu_ready_o;
    end

    always_comb begin
        exu_vld_d  = exu_vld_q;
        exu_wen_d  = exu_wen_q;
        exu_rd_d   = exu_rd_q;
        exu_data_d = exu_data_q;
        if (acc_exu) begin
            exu_vld_d  = 1'b1;
            exu_wen_d  = exu_wen_i;
            exu_rd_d   = exu_rd_i;
            exu_data_d = exu_data_i;
        end else if (drain_exu) begin
            exu_vld_d  = 1'b0;
        end
    end

    always_comb begin
        lsu_vld_d  = lsu_vld_q;
        lsu_wen_d  = lsu_wen_q;
        lsu_rd_d   = lsu_rd_q;
        lsu_data_d = lsu_data_q;
        if (acc_lsu) begin
            lsu_vld_d  = 1'b1;
            lsu_wen_d  = lsu_wen_i;
            lsu_rd_d   = lsu_rd_i;
            lsu_data_d = lsu_data_i;
        end else if (drain_lsu) begin
            lsu_vld_d  = 1'b0;
        end
    end

    // Two fresh entries on one edge: LSU ranks older. A lone fresh entry is younger than
    // whatever the other slot still holds.
    always_comb begin
        age_d = age_q;
        if (acc_exu && acc_lsu) begin
            age_d = 1'b1;
        end else if (acc_exu) begin
            age_d = lsu_vld_d;
        end else if (acc_lsu) begin
            age_d = 1'b0;
        end
    end

    always_comb begin
        rf_wen_d  = 1'b0;
        commit_d  = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_din_d  = rf_din_q;
        if (drain_exu) begin
            commit_d  = 1'b1;
            rf_wen_d  = exu_wen_q & (exu_rd_q != '0);
            rf_addr_d = exu_rd_q;
            rf_din_d  = exu_data_q;
        end else if (drain_lsu) begin
            commit_d  = 1'b1;
            rf_wen_d  = lsu_wen_q & (lsu_rd_q != '0);
            rf_addr_d = lsu_rd_q;
            rf_din_d  = lsu_data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exu_vld_q  <= 1'b0;
            exu_wen_q  <= 1'b0;
            exu_rd_q   <= '0;
            exu_data_q <= '0;
            lsu_vld_q  <= 1'b0;
            lsu_wen_q  <= 1'b0;
            lsu_rd_q   <= '0;
            lsu_data_q <= '0;
            age_q      <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_addr_q  <= '0;
            rf_din_q   <= '0;
            commit_q   <= 1'b0;
        end else begin
            exu_vld_q  <= exu_vld_d;
            exu_wen_q  <= exu_wen_d;
            exu_rd_q   <= exu_rd_d;
            exu_data_q <= exu_data_d;
            lsu_vld_q  <= lsu_vld_d;
            lsu_wen_q  <= lsu_wen_d;
            lsu_rd_q   <= lsu_rd_d;
            lsu_data_q <= lsu_data_d;
            age_q      <= age_d;
            rf_wen_q   <= rf_wen_d;
            rf_addr_q  <= rf_addr_d;
            rf_din_q   <= rf_din_d;
            commit_q   <= commit_d;
        end
    end

    assign rf_wen_o  = rf_wen_q;
    assign rf_addr_o = rf_addr_q;
    assign rf_din_o  = rf_din_q;
    assign commit_o  = commit_q;

    function automatic logic hit(input logic                  vld,
                                 input logic [ADDR_WIDTH-1:0] rd,
                                 input logic [ADDR_WIDTH-1:0] query);
        return vld & (rd == query) & (query != '0);
    endfunction

    logic exu_hit1, lsu_hit1, rf_hit1;
    logic exu_hit2, lsu_hit2, rf_hit2;

    // rf_wen_q already excludes x0, so the output register needs no separate wen term.
    always_comb begin
        exu_hit1 = hit(exu_vld_q & exu_wen_q, exu_rd_q, query_addr1_i);
        lsu_hit1 = hit(lsu_vld_q & lsu_wen_q, lsu_rd_q, query_addr1_i);
        rf_hit1  = hit(rf_wen_q, rf_addr_q, query_addr1_i);
        exu_hit2 = hit(exu_vld_q & exu_wen_q, exu_rd_q, query_addr2_i);
        lsu_hit2 = hit(lsu_vld_q & lsu_wen_q, lsu_rd_q, query_addr2_i);
        rf_hit2  = hit(rf_wen_q, rf_addr_q, query_addr2_i);
        busy1_o  = exu_hit1 | lsu_hit1 | rf_hit1;
        busy2_o  = exu_hit2 | lsu_hit2 | rf_hit2;
    end

`ifdef YSYX_23060229_WB_FORWARD_EN
    function automatic logic [DATA_WIDTH-1:0] pick(input logic                  young_hit,
                                                   input logic [DATA_WIDTH-1:0] young_data,
                                                   input logic                  old_hit,
                                                   input logic [DATA_WIDTH-1:0] old_data,
                                                   input logic                  reg_hit,
                                                   input logic [DATA_WIDTH-1:0] reg_data);
        if (young_hit) return young_data;
        if (old_hit)   return old_data;
        if (reg_hit)   return reg_data;
        return '0;
    endfunction

    // Youngest match wins: with age_q set the EXU slot is the younger one.
    always_comb begin
        fwd_valid1_o = busy1_o;
        fwd_valid2_o = busy2_o;
        if (age_q) begin
            fwd_data1_o = pick(exu_hit1, exu_data_q, lsu_hit1, lsu_data_q, rf_hit1, rf_din_q);
            fwd_data2_o = pick(exu_hit2, exu_data_q, lsu_hit2, lsu_data_q, rf_hit2, rf_din_q);
        end else begin
            fwd_data1_o = pick(lsu_hit1, lsu_data_q, exu_hit1, exu_data_q, rf_hit1, rf_din_q);
            fwd_data2_o = pick(lsu_hit2, lsu_data_q, exu_hit2, exu_data_q, rf_hit2, rf_din_q);
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060229_wbu.sv
// Directed self-checking bench for ysyx_23060229_wbu: reset, single write, x0, ordering,
// backpressure, random stream and back-to-back retirement.
module tb_ysyx_23060229_wbu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        exu_valid_i, exu_ready_o, exu_wen_i;
    logic [4:0]  exu_rd_i;
    logic [31:0] exu_data_i;
    logic        lsu_valid_i, lsu_ready_o, lsu_wen_i;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        rf_wen_o, commit_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_din_o;
    logic [4:0]  query_addr1_i, query_addr2_i;
    logic        busy1_o, busy2_o;
`ifdef YSYX_23060229_WB_FORWARD_EN
    logic        fwd_valid1_o, fwd_valid2_o;
    logic [31:0] fwd_data1_o, fwd_data2_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0]  mon_rd[$];
    logic [31:0] mon_data[$];
    logic        mon_wen[$];
    time         mon_t[$];
    logic [31:0] rf_model[32];

    ysyx_23060229_wbu dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .exu_valid_i  (exu_valid_i),
        .exu_ready_o  (exu_ready_o),
        .exu_wen_i    (exu_wen_i),
        .exu_rd_i     (exu_rd_i),
        .exu_data_i   (exu_data_i),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_wen_i    (lsu_wen_i),
        .lsu_rd_i     (lsu_rd_i),
        .lsu_data_i   (lsu_data_i),
        .rf_wen_o     (rf_wen_o),
        .rf_addr_o    (rf_addr_o),
        .rf_din_o     (rf_din_o),
        .commit_o     (commit_o),
        .query_addr1_i(query_addr1_i),
        .query_addr2_i(query_addr2_i),
`ifdef YSYX_23060229_WB_FORWARD_EN
        .fwd_valid1_o (fwd_valid1_o),
        .fwd_valid2_o (fwd_valid2_o),
        .fwd_data1_o  (fwd_data1_o),
        .fwd_data2_o  (fwd_data2_o),
`endif
        .busy1_o      (busy1_o),
        .busy2_o      (busy2_o)
    );

    always #5 clk_i = ~clk_i;

    // Retirement monitor and register-file model, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (commit_o) begin
            mon_rd.push_back(rf_addr_o);
            mon_data.push_back(rf_din_o);
            mon_wen.push_back(rf_wen_o);
            mon_t.push_back($time);
        end
        if (rf_wen_o) rf_model[rf_addr_o] = rf_din_o;
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_mon();
        mon_rd.delete();
        mon_data.delete();
        mon_wen.delete();
        mon_t.delete();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        exu_valid_i = 1'b0; exu_wen_i = 1'b1; exu_rd_i = '0; exu_data_i = '0;
        lsu_valid_i = 1'b0; lsu_wen_i = 1'b1; lsu_rd_i = '0; lsu_data_i = '0;
    endtask

    task automatic test_reset();
        int n0;
        rst_ni = 1'b0;
        idle_inputs();
        query_addr1_i = '0;
        query_addr2_i = '0;
        repeat (2) cyc();
        chk("reset_rf_wen", rf_wen_o, 0);
        chk("reset_commit", commit_o, 0);
        chk("reset_exu_ready", exu_ready_o, 1);
        chk("reset_lsu_ready", lsu_ready_o, 1);
        rst_ni = 1'b1;
        cyc();
        // Fill both slots and keep them full, then reset mid-stream.
        exu_valid_i = 1'b1; exu_rd_i = 5'd7; exu_data_i = 32'h77;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h99;
        cyc();
        cyc();
        chk("pre_reset_rf_wen", rf_wen_o, 1);
        chk("pre_reset_rf_addr", rf_addr_o, 9);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_rf_wen", rf_wen_o, 0);
        chk("midrst_rf_addr", rf_addr_o, 0);
        chk("midrst_rf_din", rf_din_o, 0);
        chk("midrst_commit", commit_o, 0);
        chk("midrst_exu_ready", exu_ready_o, 1);
        chk("midrst_lsu_ready", lsu_ready_o, 1);
        idle_inputs();
        cyc();
        rst_ni = 1'b1;
        n0 = mon_rd.size();
        repeat (4) cyc();
        chk("post_reset_no_commit", mon_rd.size(), n0);
        chk("post_reset_exu_ready", exu_ready_o, 1);
        chk("post_reset_lsu_ready", lsu_ready_o, 1);
        chk("post_reset_r9_unwritten", rf_model[9], 0);
    endtask

    task automatic test_single();
        clear_mon();
        query_addr1_i = 5'd5;
        chk("single_busy_before", busy1_o, 0);
        exu_valid_i = 1'b1; exu_wen_i = 1'b1; exu_rd_i = 5'd5; exu_data_i = 32'hDEADBEEF;
        chk("single_exu_ready", exu_ready_o, 1);
        cyc();
        idle_inputs();
        chk("single_busy_slot", busy1_o, 1);
        chk("single_no_commit_yet", commit_o, 0);
        cyc();
        chk("single_rf_wen", rf_wen_o, 1);
        chk("single_rf_addr", rf_addr_o, 5);
        chk("single_rf_din", rf_din_o, 32'hDEADBEEF);
        chk("single_commit", commit_o, 1);
        chk("single_busy_outreg", busy1_o, 1);
        cyc();
        chk("single_rf_wen_off", rf_wen_o, 0);
        chk("single_commit_off", commit_o, 0);
        chk("single_busy_clear", busy1_o, 0);
        chk("single_rf_addr_hold", rf_addr_o, 5);
        chk("single_rf_din_hold", rf_din_o, 32'hDEADBEEF);
        chk("single_r5_written", rf_model[5], 32'hDEADBEEF);
        chk("single_commit_count", mon_rd.size(), 1);
    endtask

    task automatic test_x0();
        clear_mon();
        query_addr1_i = '0;
        query_addr2_i = '0;
        lsu_valid_i = 1'b1; lsu_wen_i = 1'b1; lsu_rd_i = '0; lsu_data_i = 32'h12345678;
        cyc();
        idle_inputs();
        chk("x0_busy1_slot", busy1_o, 0);
        chk("x0_busy2_slot", busy2_o, 0);
        cyc();
        chk("x0_commit", commit_o, 1);
        chk("x0_rf_wen", rf_wen_o, 0);
        chk("x0_rf_addr", rf_addr_o, 0);
        chk("x0_busy2_outreg", busy2_o, 0);
        cyc();
        chk("x0_commit_off", commit_o, 0);
        chk("x0_commit_count", mon_rd.size(), 1);
        chk("x0_model_r0", rf_model[0], 0);
    endtask

    task automatic test_ordering();
        clear_mon();
        query_addr1_i = 5'd3;
        query_addr2_i = 5'd4;
        lsu_valid_i = 1'b1; lsu_wen_i = 1'b1; lsu_rd_i = 5'd3; lsu_data_i = 32'hA;
        exu_valid_i = 1'b1; exu_wen_i = 1'b1; exu_rd_i = 5'd3; exu_data_i = 32'hB;
        cyc();
        idle_inputs();
        chk("order_busy1", busy1_o, 1);
        chk("order_busy2_other", busy2_o, 0);
`ifdef YSYX_23060229_WB_FORWARD_EN
        chk("order_fwd_valid1", fwd_valid1_o, 1);
        chk("order_fwd_data1_both", fwd_data1_o, 32'hB);
        chk("order_fwd_valid2", fwd_valid2_o, 0);
`endif
        cyc();
        chk("order_first_din", rf_din_o, 32'hA);
        chk("order_first_addr", rf_addr_o, 3);
`ifdef YSYX_23060229_WB_FORWARD_EN
        chk("order_fwd_data1_one", fwd_data1_o, 32'hB);
`endif
        cyc();
        chk("order_second_din", rf_din_o, 32'hB);
        chk("order_second_commit", commit_o, 1);
        cyc();
        chk("order_final_r3", rf_model[3], 32'hB);
        chk("order_commit_count", mon_rd.size(), 2);
    endtask

    task automatic test_backpressure();
        clear_mon();
        exu_valid_i = 1'b1; exu_rd_i = 5'd10; exu_data_i = 32'h100;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd11; lsu_data_i = 32'h101;
        cyc();
        lsu_valid_i = 1'b0;
        exu_rd_i = 5'd12; exu_data_i = 32'h102;
        chk("bp_exu_ready_blocked", exu_ready_o, 0);
        chk("bp_lsu_ready_draining", lsu_ready_o, 1);
        cyc();
        chk("bp_lsu_retired", rf_din_o, 32'h101);
        chk("bp_exu_ready_draining", exu_ready_o, 1);
        cyc();
        idle_inputs();
        repeat (3) cyc();
        chk("bp_count", mon_data.size(), 3);
        if (mon_data.size() == 3) begin
            chk("bp_seq0", mon_data[0], 32'h101);
            chk("bp_seq1", mon_data[1], 32'h100);
            chk("bp_seq2", mon_data[2], 32'h102);
        end
    endtask

    task automatic test_random_stream();
        logic [4:0]  exp_rd[$];
        logic [31:0] exp_data[$];
        logic        exp_wen[$];
        logic        e_pend, l_pend, e_acc, l_acc;
        int          nexp, nmin;
        clear_mon();
        e_pend = 1'b0;
        l_pend = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!e_pend) begin
                exu_valid_i = 1'($urandom_range(0, 1));
                exu_rd_i    = 5'($urandom_range(0, 31));
                exu_wen_i   = ($urandom_range(0, 3) != 0);
                exu_data_i  = 32'hE000_0000 | 32'(c);
            end
            if (!l_pend) begin
                lsu_valid_i = 1'($urandom_range(0, 1));
                lsu_rd_i    = 5'($urandom_range(0, 31));
                lsu_wen_i   = ($urandom_range(0, 3) != 0);
                lsu_data_i  = 32'hA000_0000 | 32'(c);
            end
            e_acc = exu_valid_i & exu_ready_o;
            l_acc = lsu_valid_i & lsu_ready_o;
            // Same-edge acceptances retire LSU first.
            if (l_acc) begin
                exp_rd.push_back(lsu_rd_i);
                exp_data.push_back(lsu_data_i);
                exp_wen.push_back(lsu_wen_i & (lsu_rd_i != 0));
            end
            if (e_acc) begin
                exp_rd.push_back(exu_rd_i);
                exp_data.push_back(exu_data_i);
                exp_wen.push_back(exu_wen_i & (exu_rd_i != 0));
            end
            e_pend = exu_valid_i & ~e_acc;
            l_pend = lsu_valid_i & ~l_acc;
            cyc();
        end
        idle_inputs();
        repeat (4) cyc();
        nexp = exp_data.size();
        chk("rand_count", mon_data.size(), nexp);
        nmin = (mon_data.size() < nexp) ? mon_data.size() : nexp;
        for (int i = 0; i < nmin; i++) begin
            n_tests++;
            if (mon_data[i] !== exp_data[i] || mon_rd[i] !== exp_rd[i] ||
                mon_wen[i] !== exp_wen[i]) begin
                n_fail++;
                $display("FAIL rand_entry%0d: got rd=%0d data=%0h wen=%0b expected rd=%0d data=%0h wen=%0b",
                         i, mon_rd[i], mon_data[i], mon_wen[i], exp_rd[i], exp_data[i], exp_wen[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        for (int i = 1; i <= 8; i++) begin
            exu_valid_i = 1'b1; exu_wen_i = 1'b1;
            exu_rd_i = 5'(i); exu_data_i = 32'h1000 + 32'(i);
            chk("b2b_exu_ready", exu_ready_o, 1);
            cyc();
        end
        idle_inputs();
        repeat (3) cyc();
        chk("b2b_count", mon_rd.size(), 8);
        if (mon_rd.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("b2b_rd", mon_rd[i], 32'(i + 1));
                chk("b2b_data", mon_data[i], 32'h1000 + 32'(i + 1));
                if (i > 0) chk("b2b_no_bubble", 32'(mon_t[i] - mon_t[i-1]), 10);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        test_reset();
        test_single();
        test_x0();
        test_ordering();
        test_backpressure();
        test_random_stream();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
